// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared defaults, FSM state encoding and text-screen geometry
//               for the VGA text-RAM write path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_ADDR_W       = 12;
    localparam int c_DATA_W       = 16;
    localparam int c_SCREEN_WORDS = 2400;  // 80 columns x 30 rows

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_FILL = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vga_fill_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fill_counter
// Description : Fill address / remaining-word register pair. The address wraps
//               modulo 2^ADDR_W; o_last flags the final word of the region.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fill_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_cur_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_load_addr;
            r_remaining <= i_load_len;
        end else if (i_step) begin
            // Natural overflow of the address register gives the wrap to 0.
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - (ADDR_W+1)'(1);
        end
    end

    assign o_cur_addr = r_addr;
    assign o_last     = (r_remaining == (ADDR_W+1)'(1));

endmodule
`default_nettype wire

// File: rtl/vga_ram_write_arb.sv
`default_nettype none
// ============================================================================
// Module      : vga_ram_write_arb
// Description : Arbitrates the text-RAM write port between CPU writes and a
//               hardware region fill, with bounded CPU priority during fills.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ram_write_arb
    import vga_pkg::*;
#(
    parameter int ADDR_W       = c_ADDR_W,
    parameter int DATA_W       = c_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [DATA_W-1:0]     r_fill_data;
    logic [ADDR_W-1:0]     w_cur_addr;
    logic                  w_last;
    logic                  w_load;
    logic                  w_grant_fill;
    logic                  w_grant_cpu;

    // Fill wins whenever the CPU is idle or has used up its burst allowance.
    assign w_grant_fill = (r_state == c_ST_FILL) &&
                          (!cpu_req || (r_starve_cnt == c_STARVE_MAX));
    assign w_grant_cpu  = cpu_req && !w_grant_fill && !rst;
    assign cpu_ack      = w_grant_cpu;

    assign w_load    = (r_state == c_ST_IDLE) && fill_start;
    assign fill_busy = (r_state == c_ST_FILL);
    assign fill_done = (r_state == c_ST_DONE);

    vga_fill_counter #(
        .ADDR_W (ADDR_W)
    ) u_fill_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_addr (fill_addr),
        .i_load_len  (fill_len),
        .i_step      (w_grant_fill),
        .o_cur_addr  (w_cur_addr),
        .o_last      (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (fill_start) begin
                    w_state_next = (fill_len != '0) ? c_ST_FILL : c_ST_DONE;
                end
            end
            c_ST_FILL: begin
                if (w_grant_fill && w_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_data <= '0;
        end else if (w_load) begin
            r_fill_data <= fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (r_state != c_ST_FILL || w_grant_fill) begin
            r_starve_cnt <= '0;
        end else if (w_grant_cpu && r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
        end
    end

    // Address and data hold their last value when no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (w_grant_fill) begin
            ram_we    <= 1'b1;
            ram_addr  <= w_cur_addr;
            ram_wdata <= r_fill_data;
        end else if (w_grant_cpu) begin
            ram_we    <= 1'b1;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
        end else begin
            ram_we    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_ram_write_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_ram_write_arb
// Description : Directed self-checking bench for vga_ram_write_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_ram_write_arb;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        fill_start;
    logic [11:0] fill_addr;
    logic [12:0] fill_len;
    logic [15:0] fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;

    int checks   = 0;
    int failures = 0;

    vga_ram_write_arb dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr(input logic we, input logic [11:0] a, input logic [15:0] d);
        return {3'b000, we, a, d};
    endfunction

    task automatic start_fill(input logic [11:0] a, input logic [12:0] l, input logic [15:0] d);
        fill_start = 1'b1;
        fill_addr  = a;
        fill_len   = l;
        fill_data  = d;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_addr;
        logic [11:0] ncpu;
        logic [11:0] nfill;
        logic        exp_fill;

        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 12'h055; cpu_wdata = 16'h5555;
        fill_start = 1'b0; fill_addr = '0; fill_len = '0; fill_data = '0;
        #2;
        check("ack_in_reset", {31'd0, cpu_ack}, 32'd0);
        tick(); tick();
        check("reset_ram", wr(ram_we, ram_addr, ram_wdata), wr(1'b0, 12'h000, 16'h0000));
        check("reset_flags", {30'd0, fill_busy, fill_done}, 32'd0);
        cpu_req = 1'b0;
        rst = 1'b0;
        tick();

        // CPU write while idle, then address/data hold with we low.
        cpu_req = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
        #1;
        check("idle_ack", {31'd0, cpu_ack}, 32'd1);
        tick();
        cpu_req = 1'b0;
        check("idle_cpu_write", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'h123, 16'hBEEF));
        tick();
        check("idle_hold", wr(ram_we, ram_addr, ram_wdata), wr(1'b0, 12'h123, 16'hBEEF));

        // Zero-length fill: done next cycle, never busy, no write.
        start_fill(12'h040, 13'd0, 16'hDEAD);
        check("len0_flags", {30'd0, fill_busy, fill_done}, 32'd1);
        check("len0_we", {31'd0, ram_we}, 32'd0);
        tick();
        check("len0_after", {29'd0, fill_busy, fill_done, ram_we}, 32'd0);

        // Full screen clear with no CPU traffic.
        start_fill(12'h000, 13'd2400, 16'h0720);
        check("screen_busy", {31'd0, fill_busy}, 32'd1);
        check("screen_first_idle", {31'd0, ram_we}, 32'd0);
        for (int i = 0; i < 2400; i++) begin
            tick();
            exp_addr = 12'(i);
            check("screen_word", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, exp_addr, 16'h0720));
        end
        check("screen_done", {30'd0, fill_busy, fill_done}, 32'd1);
        tick();
        check("screen_after", {29'd0, fill_busy, fill_done, ram_we}, 32'd0);

        // Wrap at the top of the address space.
        start_fill(12'd4094, 13'd4, 16'h1234);
        tick();
        check("wrap_w0", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'd4094, 16'h1234));
        tick();
        check("wrap_w1", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'd4095, 16'h1234));
        tick();
        check("wrap_w2", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'd0, 16'h1234));
        tick();
        check("wrap_w3", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'd1, 16'h1234));
        check("wrap_done", {31'd0, fill_done}, 32'd1);
        tick();

        // Second fill_start mid-fill must be ignored.
        start_fill(12'd100, 13'd6, 16'hAAAA);
        fill_start = 1'b1; fill_addr = 12'd500; fill_len = 13'd3; fill_data = 16'hBBBB;
        tick();
        fill_start = 1'b0;
        check("restart_w0", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'd100, 16'hAAAA));
        for (int i = 1; i < 6; i++) begin
            tick();
            exp_addr = 12'(100 + i);
            check("restart_word", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, exp_addr, 16'hAAAA));
        end
        check("restart_done", {31'd0, fill_done}, 32'd1);
        tick();
        check("restart_idle", {29'd0, fill_busy, fill_done, ram_we}, 32'd0);

        // CPU held busy during a 20-word fill: 8 CPU grants, then 1 fill grant.
        start_fill(12'h300, 13'd20, 16'h5A5A);
        ncpu = '0; nfill = '0;
        for (int k = 0; k < 180; k++) begin
            cpu_req = 1'b1; cpu_addr = 12'h800 + ncpu; cpu_wdata = {4'hC, ncpu};
            exp_fill = ((k % 9) == 8);
            #1;
            check("starve_ack", {31'd0, cpu_ack}, {31'd0, !exp_fill});
            tick();
            if (exp_fill) begin
                check("starve_fill", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'h300 + nfill, 16'h5A5A));
                nfill = nfill + 12'd1;
            end else begin
                check("starve_cpu", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'h800 + ncpu, {4'hC, ncpu}));
                ncpu = ncpu + 12'd1;
            end
        end
        cpu_req = 1'b0;
        check("starve_done", {30'd0, fill_busy, fill_done}, 32'd1);
        tick();

        // Reset after 10 fill words aborts without fill_done.
        start_fill(12'h200, 13'd30, 16'h1111);
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_addr = 12'h200 + 12'(i);
            check("abort_word", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, exp_addr, 16'h1111));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ram", wr(ram_we, ram_addr, ram_wdata), wr(1'b0, 12'h000, 16'h0000));
        check("abort_flags", {30'd0, fill_busy, fill_done}, 32'd0);
        tick();
        check("abort_no_done", {29'd0, fill_busy, fill_done, ram_we}, 32'd0);

        start_fill(12'h010, 13'd2, 16'h2222);
        tick();
        check("post_w0", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'h010, 16'h2222));
        tick();
        check("post_w1", wr(ram_we, ram_addr, ram_wdata), wr(1'b1, 12'h011, 16'h2222));
        check("post_done", {31'd0, fill_done}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
